// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard for RAW hazard stalls.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter  int unsigned XLEN     = 32,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned NWR      = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_ok;
  logic [AW-1:0]    rd_addr;
  logic [XLEN-1:0]  rd_data;
  logic             rd_bsy;

  function automatic logic zero_addr(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Low on the edge where reset releases, so a write or alloc landing there is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_ok <= 1'b0;
    else        wr_ok <= 1'b1;
  end

  // Register array; later (higher) ports override earlier ones on address conflict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < int'(NREGS); r++) regs[r] <= '0;
    end else if (wr_ok) begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && !zero_addr(wa[j*AW +: AW])) regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  // Writes retire their producer; a same-cycle alloc is younger and wins
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j] && !zero_addr(wa[j*AW +: AW])) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    if (alloc_en && !zero_addr(alloc_addr)) busy_nxt[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy <= '0;
    else if (wr_ok) busy <= busy_nxt;
  end

  // Combinational read ports
  always_comb begin
    rd      = '0;
    rbusy   = '0;
    rd_addr = '0;
    rd_data = '0;
    rd_bsy  = 1'b0;
    for (int i = 0; i < int'(NRD); i++) begin
      rd_addr = ra[i*AW +: AW];
      rd_data = regs[rd_addr];
      rd_bsy  = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < int'(NWR); j++) begin
        if (wr_ok && we[j] && (wa[j*AW +: AW] == rd_addr)) begin
          rd_data = wd[j*XLEN +: XLEN];
          rd_bsy  = alloc_en && (alloc_addr == rd_addr);
        end
      end
`endif
      if (zero_addr(rd_addr) || !rst_n) begin
        rd_data = '0;
        rd_bsy  = 1'b0;
      end
      rd[i*XLEN +: XLEN] = rd_data;
      rbusy[i]           = rd_bsy;
    end
  end

  assign busy_vec = busy;

endmodule
